instr_prefetch_unit: RTL

INSTR_PREFETCH_UNIT -- requirements
Module: instr_prefetch_unit

---
 rtl/instr_prefetch_unit.sv | 64 ++++++
 1 files changed

// File: rtl/instr_prefetch_unit.sv
// instr_prefetch_unit: single-outstanding instruction prefetch queue with redirect flush.
// Define PREFETCH_BYPASS_EN to forward an ack straight to the outputs when the queue is empty.
module instr_prefetch_unit #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [7:0]  redirect_target,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instruction,
  output logic [7:0]  PC_out,
  output logic        valid
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]    fetch_ptr, nxt_ptr;
  logic          discard, acc, take, push, pop, byp, q_valid;
  logic [AW-1:0] head, tail;
  logic [AW:0]   count, count_nxt;
  logic [23:0]   mem [DEPTH];
  assign acc = imem_ack & imem_req;
  // a response that was in flight at a redirect belongs to the abandoned stream
  assign take = acc & ~discard & ~redirect;
  assign q_valid = count != '0;
`ifdef PREFETCH_BYPASS_EN
  assign byp = take & ~q_valid;
`else
  assign byp = 1'b0;
`endif
  assign push = take & ~(byp & ~stall);
  assign pop = q_valid & ~stall & ~redirect;
  assign count_nxt = redirect ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
  assign nxt_ptr = redirect ? redirect_target : fetch_ptr + 8'(take);
  assign valid = q_valid | byp;
  assign instruction = q_valid ? mem[head][15:0] : byp ? imem_rdata : 16'h0000;
  assign PC_out = q_valid ? mem[head][23:16] : byp ? imem_addr : 8'h00;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fetch_ptr <= 8'h00;
      discard <= 1'b0;
      head <= '0;
      tail <= '0;
      count <= '0;
      imem_req <= 1'b0;
      imem_addr <= 8'h00;
    end else begin
      count <= count_nxt;
      head <= redirect ? '0 : head + AW'(pop);
      tail <= redirect ? '0 : tail + AW'(push);
      discard <= redirect ? imem_req & ~imem_ack : discard & ~acc;
      fetch_ptr <= nxt_ptr;
      // request is held until acked; a fresh one only fits if a slot will be free
      if (!imem_req || acc) begin
        imem_req <= count_nxt < (AW+1)'(DEPTH);
        imem_addr <= nxt_ptr;
      end
    end
  always_ff @(posedge clk)
    if (push) mem[tail] <= {imem_addr, imem_rdata};
endmodule
